// File: rtl/dsp_audio_pkg.sv
// Shared audio types for the DSP output path: sample/stereo typedefs and frame constants.
package dsp_audio_pkg;

   localparam int unsigned DSP_FRAME_CLKS   = 64;
   localparam int unsigned DSP_SAMPLE_WIDTH = 16;

   typedef logic signed [DSP_SAMPLE_WIDTH-1:0] dsp_sample_t;

   typedef struct packed {
      dsp_sample_t l;
      dsp_sample_t r;
   } dsp_stereo_t;

   typedef enum logic {
      CG_IDLE = 1'b0,
      CG_RUN  = 1'b1
   } dsp_clkgen_state_t;

endpackage

// File: rtl/dsp_i2s_clkgen.sv
// I2S frame timing: counter, enable gating, registered bclk/lrclk and frame load strobe.
// Define DSP_I2S_LEFT_JUSTIFIED_EN for left-justified word-select polarity.
module dsp_i2s_clkgen
   import dsp_audio_pkg::*;
#(
   parameter int unsigned SLOT_BITS    = 16,
   parameter int unsigned CLKS_PER_BIT = 2,
   localparam int unsigned BIT_W       = $clog2(2 * SLOT_BITS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic             load,
   output logic             out_en,
   output logic [BIT_W-1:0] bit_idx,
   output logic             frame_start,
   output logic             i2s_bclk,
   output logic             i2s_lrclk
);

   localparam int unsigned      FRAME_CLKS = 2 * SLOT_BITS * CLKS_PER_BIT;
   localparam int unsigned      CNT_W      = $clog2(FRAME_CLKS);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CLKS - 1);

   dsp_clkgen_state_t state_q, state_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [31:0]       cnt_w;
   logic              bclk_n, lrclk_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= CG_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   // Leaving IDLE always loads, so re-enable and the first edge after reset start a fresh frame.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      load    = 1'b0;
      if (!enable) begin
         state_n = CG_IDLE;
         cnt_n   = '0;
      end else begin
         state_n = CG_RUN;
         if (state_q == CG_IDLE || cnt_q == CNT_LAST) begin
            load  = 1'b1;
            cnt_n = '0;
         end else begin
            cnt_n = cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_en  = enable && (state_q == CG_RUN);
   assign cnt_w   = 32'(cnt_q);
   assign bit_idx = BIT_W'(cnt_w / CLKS_PER_BIT);
   assign bclk_n  = (cnt_w % CLKS_PER_BIT) >= (CLKS_PER_BIT / 2);
`ifdef DSP_I2S_LEFT_JUSTIFIED_EN
   assign lrclk_n = 32'(bit_idx) < SLOT_BITS;
`else
   assign lrclk_n = 32'(bit_idx) >= SLOT_BITS;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_start <= 1'b0;
         i2s_bclk    <= 1'b0;
         i2s_lrclk   <= 1'b0;
      end else begin
         frame_start <= load;
         i2s_bclk    <= out_en & bclk_n;
         i2s_lrclk   <= out_en & lrclk_n;
      end
   end

endmodule

// File: rtl/dsp_i2s_tx.sv
// Stereo I2S transmitter: sample hold/fresh tracking, frame register and serial data output.
// Define DSP_I2S_LEFT_JUSTIFIED_EN for left-justified format (no 1-BCLK data delay).
module dsp_i2s_tx
   import dsp_audio_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned SLOT_BITS    = 16,
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_l,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_r,
   input  logic                           sample_valid,
   output logic                           frame_start,
   output logic                           underrun,
   output logic                           overrun,
   output logic                           i2s_bclk,
   output logic                           i2s_lrclk,
   output logic                           i2s_sdata
);

   localparam int unsigned WORD_BITS = 2 * SLOT_BITS;
   localparam int unsigned BIT_W     = $clog2(WORD_BITS);

   logic             load, out_en, sdata_n;
   logic [BIT_W-1:0] bit_idx, sel_idx;
   dsp_stereo_t      in_sample, hold_q, sr_q;
   logic             fresh_q;
`ifndef DSP_I2S_LEFT_JUSTIFIED_EN
   logic             lsb_q;
`endif

   dsp_i2s_clkgen #(
      .SLOT_BITS    (SLOT_BITS),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_clkgen (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .out_en      (out_en),
      .bit_idx     (bit_idx),
      .frame_start (frame_start),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk)
   );

   assign in_sample.l = sample_l;
   assign in_sample.r = sample_r;

   // Frame word is indexed by bit position instead of shifted; sdata is registered alongside bclk/lrclk.
   always_comb begin
`ifdef DSP_I2S_LEFT_JUSTIFIED_EN
      sel_idx = BIT_W'(WORD_BITS - 1 - 32'(bit_idx));
      sdata_n = sr_q[sel_idx];
`else
      sel_idx = BIT_W'(WORD_BITS - 32'(bit_idx));
      sdata_n = (bit_idx == '0) ? lsb_q : sr_q[sel_idx];
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_q   <= '0;
         sr_q     <= '0;
         fresh_q  <= 1'b0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
`ifndef DSP_I2S_LEFT_JUSTIFIED_EN
         lsb_q    <= 1'b0;
`endif
      end else begin
         underrun <= 1'b0;
         overrun  <= 1'b0;
         if (load) begin
`ifndef DSP_I2S_LEFT_JUSTIFIED_EN
            lsb_q   <= sr_q.r[0];
`endif
            fresh_q <= 1'b0;
            if (sample_valid) begin
               sr_q   <= in_sample;
               hold_q <= in_sample;
            end else begin
               sr_q     <= hold_q;
               underrun <= !fresh_q;
            end
         end else if (sample_valid) begin
            hold_q  <= in_sample;
            fresh_q <= 1'b1;
            overrun <= fresh_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         i2s_sdata <= 1'b0;
      end else begin
         i2s_sdata <= out_en & sdata_n;
      end
   end

endmodule
